// File: rtl/miriscv_lsu_pkg.sv
// Shared load/store size codes, FSM state encoding and size helpers
// for the miriscv load/store unit.
package miriscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Unsigned sizes only make sense for loads; anything unknown acts as a word.
    function automatic logic [2:0] norm_size(input logic [2:0] size,
                                             input logic       we);
        logic [2:0] s;
        case (size)
            LDST_B, LDST_H, LDST_W: s = size;
            LDST_BU, LDST_HU:       s = we ? LDST_W : size;
            default:                s = LDST_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: byte enables, replicated store data,
// misalignment detection and load data extraction/extension.
module miriscv_lsu_align (
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata_raw,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] rdata
);
    import miriscv_lsu_pkg::*;

    logic        is_byte;
    logic        is_half;
    logic        sext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign is_byte = (size == LDST_B) || (size == LDST_BU);
    assign is_half = (size == LDST_H) || (size == LDST_HU);
    assign sext    = ~size[2];
    assign rbyte   = rdata_raw[{offset, 3'b000} +: 8];
    assign rhalf   = offset[1] ? rdata_raw[31:16] : rdata_raw[15:0];

    always_comb begin
        be       = 4'b1111;
        wdata    = wdata_raw;
        misalign = 1'b0;
        rdata    = rdata_raw;
        unique case (1'b1)
            is_byte: begin
                be    = 4'b0001 << offset;
                wdata = {4{wdata_raw[7:0]}};
                rdata = {{24{sext & rbyte[7]}}, rbyte};
            end
            is_half: begin
                be       = 4'b0011 << {offset[1], 1'b0};
                wdata    = {2{wdata_raw[15:0]}};
                misalign = offset[0];
                rdata    = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: begin
                misalign = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: req/gnt/rvalid data-memory handshake, core stall,
// access timeout and load writeback data.
module miriscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    import miriscv_lsu_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       size_q;
    logic [1:0]       offset_q;
    logic [2:0]       size_in;
    logic [2:0]       size_sel;
    logic [1:0]       offset_sel;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             misalign;
    logic             idle;
    logic             issue;
    logic             timeout;

    assign idle       = (state == LSU_IDLE);
    assign size_in    = norm_size(lsu_size_i, lsu_we_i);
    // Outside IDLE the lane logic works on the captured access for extraction.
    assign size_sel   = idle ? size_in : size_q;
    assign offset_sel = idle ? lsu_addr_i[1:0] : offset_q;

    miriscv_lsu_align u_align (
        .size      (size_sel),
        .offset    (offset_sel),
        .wdata_raw (lsu_data_i),
        .rdata_raw (data_rdata_i),
        .be        (be),
        .wdata     (wdata),
        .misalign  (misalign),
        .rdata     (rdata)
    );

    assign issue   = idle && lsu_req_i && !misalign;
    assign timeout = (cnt >= CNT_LAST);
    assign cnt_nxt = cnt + CNT_ONE;

    assign lsu_stall_req_o = issue
                          || (state == LSU_REQ)
                          || (state == LSU_RESP);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state          <= LSU_IDLE;
            cnt            <= '0;
            size_q         <= '0;
            offset_q       <= '0;
            lsu_data_o     <= '0;
            lsu_misalign_o <= 1'b0;
            lsu_err_o      <= 1'b0;
            data_req_o     <= 1'b0;
            data_we_o      <= 1'b0;
            data_be_o      <= '0;
            data_addr_o    <= '0;
            data_wdata_o   <= '0;
        end else begin
            lsu_misalign_o <= 1'b0;
            lsu_err_o      <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    lsu_misalign_o <= lsu_req_i & misalign;
                    if (issue) begin
                        state        <= LSU_REQ;
                        cnt          <= '0;
                        size_q       <= size_in;
                        offset_q     <= lsu_addr_i[1:0];
                        data_req_o   <= 1'b1;
                        data_we_o    <= lsu_we_i;
                        data_be_o    <= be;
                        data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                        data_wdata_o <= wdata;
                    end
                end
                LSU_REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        cnt        <= cnt_nxt;
                        if (data_rvalid_i) begin
                            state <= LSU_DONE;
                            if (!data_we_o) lsu_data_o <= rdata;
                        end else begin
                            state <= LSU_RESP;
                        end
                    end else if (timeout) begin
                        state      <= LSU_DONE;
                        data_req_o <= 1'b0;
                        lsu_err_o  <= 1'b1;
                        lsu_data_o <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                LSU_RESP: begin
                    if (data_rvalid_i) begin
                        state <= LSU_DONE;
                        if (!data_we_o) lsu_data_o <= rdata;
                    end else if (timeout) begin
                        state      <= LSU_DONE;
                        lsu_err_o  <= 1'b1;
                        lsu_data_o <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                // The finishing instruction is still presented here; never re-issue it.
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu: directed accesses push expected
// memory requests and completions; a negedge monitor pops and compares.
module tb_miriscv_lsu;

    localparam int TO = 256;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_misalign_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        mis;
        logic        err;
        logic [31:0] data;
    } res_t;

    req_t reqq[$];
    res_t resq[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_stall = 1'b0;

    miriscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_misalign_o  (lsu_misalign_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [68:0] act,
                         input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: memory handshakes and completions/misalign pulses.
    always @(negedge clk) begin
        req_t r;
        res_t s;
        if (rst_n_i === 1'b1) begin
            if (data_req_o && data_gnt_i) begin
                if (reqq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_extra: got unexpected request addr %h",
                             data_addr_o);
                end else begin
                    r = reqq.pop_front();
                    check("req", {data_we_o, data_be_o, data_addr_o, data_wdata_o}, r);
                end
            end
            if (lsu_misalign_o || (prev_stall && !lsu_stall_req_o)) begin
                if (resq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_extra: got unexpected completion data %h",
                             lsu_data_o);
                end else begin
                    s = resq.pop_front();
                    check("res", {lsu_misalign_o, lsu_err_o, lsu_data_o}, s);
                end
            end
        end
        prev_stall = (rst_n_i === 1'b1) ? lsu_stall_req_o : 1'b0;
    end

    // One access; gd/rvd = wait cycles before gnt/rvalid, rvd<0 means rvalid with gnt.
    task automatic xfer(input string nm, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int gd, input int rvd,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] edata, input logic eerr,
                        input int estall, input int ereqhi);
        req_t        r;
        res_t        s;
        int          stl;
        int          reqhi;
        int          chg;
        int          rq;
        int          rs;
        logic        granted;
        logic        ok;
        logic [67:0] snap;
        if (!eerr) begin
            r.we    = we;
            r.be    = ebe;
            r.addr  = {a[31:2], 2'b00};
            r.wdata = ewd;
            reqq.push_back(r);
        end
        s.mis  = 1'b0;
        s.err  = eerr;
        s.data = edata;
        resq.push_back(s);
        stl = 0; reqhi = 0; chg = 0; rq = 0; rs = 0;
        granted = 1'b0; ok = 1'b0; snap = '0;
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = sz;
        lsu_addr_i = a;
        lsu_data_i = d;
        for (int c = 0; c < 700; c++) begin
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (data_req_o) begin
                reqhi++;
                if (reqhi == 1) snap = {data_addr_o, data_be_o, data_wdata_o};
                else if (snap != {data_addr_o, data_be_o, data_wdata_o}) chg++;
                if (rq == gd) begin
                    data_gnt_i = 1'b1;
                    granted    = 1'b1;
                    if (rvd < 0) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = rd;
                    end
                end
                rq++;
            end else if (granted && rvd >= 0) begin
                if (rs == rvd) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rd;
                end
                rs++;
            end
            @(negedge clk);
            if (lsu_stall_req_o) stl++;
            else if (c > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_bound: got no completion within 700 cycles", nm);
        end
        check({nm, "_stall"}, stl, estall);
        check({nm, "_req_done"}, data_req_o, 1'b0);
        if (ereqhi >= 0) begin
            check({nm, "_req_hold"}, reqhi, ereqhi);
            check({nm, "_req_stable"}, chg, 0);
        end
        @(posedge clk);
        #1;
        lsu_req_i     = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
    endtask

    task automatic misal(input string nm, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] edata);
        res_t s;
        int   reqs;
        int   pulses;
        s.mis  = 1'b1;
        s.err  = 1'b0;
        s.data = edata;
        resq.push_back(s);
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = sz;
        lsu_addr_i = a;
        lsu_data_i = '0;
        @(negedge clk);
        check({nm, "_stall"}, lsu_stall_req_o, 1'b0);
        @(posedge clk);
        #1;
        lsu_req_i = 1'b0;
        reqs = 0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_req_o) reqs++;
            if (lsu_misalign_o) pulses++;
        end
        check({nm, "_noreq"}, reqs, 0);
        check({nm, "_pulse"}, pulses, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_t r;
        rst_n_i       = 1'b0;
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_size_i    = '0;
        lsu_addr_i    = '0;
        lsu_data_i    = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem", {data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o}, '0);
        check("rst_data", lsu_data_o, 32'h0);
        check("rst_flags", {lsu_misalign_o, lsu_err_o, lsu_stall_req_o}, 3'b000);
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;

        xfer("sw", 1, SZ_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
             4'b1111, 32'hDEADBEEF, 32'h0, 0, 3, -1);
        xfer("lb", 0, SZ_B, 32'h103, 32'h0, 32'h80123456, 0, 0,
             4'b1000, 32'h0, 32'hFFFFFF80, 0, 3, -1);
        xfer("lbu", 0, SZ_BU, 32'h103, 32'h0, 32'h80123456, 0, 0,
             4'b1000, 32'h0, 32'h00000080, 0, 3, -1);
        xfer("sh", 1, SZ_H, 32'h202, 32'h0000ABCD, 32'h0, 0, 0,
             4'b1100, 32'hABCDABCD, 32'h00000080, 0, 3, -1);
        xfer("lh", 0, SZ_H, 32'h202, 32'h0, 32'h7FFF0000, 0, 0,
             4'b1100, 32'h0, 32'h00007FFF, 0, 3, -1);
        misal("lw_mis", SZ_W, 32'h101, 32'h00007FFF);
        misal("lh_mis", SZ_H, 32'h203, 32'h00007FFF);
        xfer("lw_wait", 0, SZ_W, 32'h300, 32'h0, 32'h12345678, 5, 3,
             4'b1111, 32'h0, 32'h12345678, 0, 11, 6);
        xfer("lhu_same", 0, SZ_HU, 32'h302, 32'h0, 32'hBEEF1234, 0, -1,
             4'b1100, 32'h0, 32'h0000BEEF, 0, 2, -1);
        xfer("lb_pos", 0, SZ_B, 32'h101, 32'h0, 32'h00007F00, 0, 0,
             4'b0010, 32'h0, 32'h0000007F, 0, 3, -1);
        xfer("sb", 1, SZ_B, 32'h102, 32'h000000A5, 32'h0, 1, 1,
             4'b0100, 32'hA5A5A5A5, 32'h0000007F, 0, 5, 2);
        xfer("sbu_ill", 1, SZ_BU, 32'h400, 32'h11223344, 32'h0, 0, 0,
             4'b1111, 32'h11223344, 32'h0000007F, 0, 3, -1);
        xfer("ld011", 0, 3'b011, 32'h404, 32'h0, 32'hCAFEF00D, 0, 0,
             4'b1111, 32'h0, 32'hCAFEF00D, 0, 3, -1);
        xfer("ld110", 0, 3'b110, 32'h408, 32'h0, 32'h0BADC0DE, 0, 0,
             4'b1111, 32'h0, 32'h0BADC0DE, 0, 3, -1);

        r.we = 1'b0; r.be = 4'b1111; r.addr = 32'h600; r.wdata = 32'h0;
        reqq.push_back(r);
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = SZ_W;
        lsu_addr_i = 32'h600;
        lsu_data_i = '0;
        @(posedge clk);
        #1;
        data_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        data_gnt_i = 1'b0;
        lsu_req_i  = 1'b0;
        rst_n_i    = 1'b0;
        @(negedge clk);
        check("resp_stall", lsu_stall_req_o, 1'b1);
        @(posedge clk);
        #1;
        rst_n_i       = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFFFFFF;
        @(negedge clk);
        check("rst_resp_out", {lsu_stall_req_o, data_req_o, data_be_o, lsu_data_o}, '0);
        @(posedge clk);
        #1;
        data_rvalid_i = 1'b0;
        @(negedge clk);
        check("late_rvalid", {lsu_stall_req_o, data_req_o, lsu_err_o, lsu_data_o}, '0);
        @(posedge clk);
        #1;

        xfer("lw_pre", 0, SZ_W, 32'h700, 32'h0, 32'h55AA55AA, 0, 0,
             4'b1111, 32'h0, 32'h55AA55AA, 0, 3, -1);
        xfer("timeout", 0, SZ_W, 32'h500, 32'h0, 32'h0, 100000, 0,
             4'b1111, 32'h0, 32'h0, 1, TO + 1, TO);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reqq_empty", reqq.size(), 0);
        check("resq_empty", resq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
